// File: rtl/debouncer_array_if.sv
// Button-bus interface for debouncer_array: raw button lines in, clean levels and pulses out.
// The master side drives the raw buttons; the slave side is the debouncer itself.
interface debouncer_array_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] boton;
  logic [N_CH-1:0] salida;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] repeat_o;

  modport master (
    output boton,
    input  salida, rise, fall, pending, repeat_o
  );

  modport slave (
    input  boton,
    output salida, rise, fall, pending, repeat_o
  );
endinterface

// File: rtl/debouncer_array.sv
// Multi-channel push-button debouncer: 2-flop sync, shared tick prescaler, per-channel stability counter.
// Define DEBOUNCER_ARRAY_REPEAT_EN to add hold-to-repeat pulses on repeat_o; otherwise repeat_o is 0.
module debouncer_array #(
  parameter int N_CH   = 4,
  parameter int STABLE = 200,
  parameter int DIV    = 1,
  parameter int HOLD   = 1000,
  parameter int RPT    = 250
) (
  input logic               clk,
  input logic               rst,
  debouncer_array_if.slave  bus
);

  localparam int MAX_SH  = (STABLE > HOLD) ? STABLE : HOLD;
  localparam int MAX_ALL = (MAX_SH > RPT) ? MAX_SH : RPT;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int PW      = $clog2(DIV + 1);

  logic [PW-1:0]            pre_q, pre_d;
  logic                     tick;
  logic [N_CH-1:0]          s1_q, s2_q;
  logic [N_CH-1:0][CW-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]          salida_q, salida_d;
  logic [N_CH-1:0]          rise_q, rise_d;
  logic [N_CH-1:0]          fall_q, fall_d;
  logic [N_CH-1:0]          pending_w;

  // With DIV=1 the prescaler sits at 0, which already equals DIV-1, so tick stays high.
  assign tick = (pre_q == PW'(DIV - 1));

  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_comb begin
    salida_d = salida_q;
    rise_d   = '0;
    fall_d   = '0;
    cnt_d    = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (s2_q[i] == salida_q[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == CW'(STABLE - 1)) begin
          cnt_d[i]    = '0;
          salida_d[i] = s2_q[i];
          rise_d[i]   = s2_q[i];
          fall_d[i]   = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      cnt_q    <= '0;
      salida_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      pre_q    <= pre_d;
      s1_q     <= bus.boton;
      s2_q     <= s1_q;
      cnt_q    <= cnt_d;
      salida_q <= salida_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  always_comb begin
    pending_w = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending_w[i] = (cnt_q[i] != '0);
    end
  end

  assign bus.salida  = salida_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.pending = pending_w;

`ifdef DEBOUNCER_ARRAY_REPEAT_EN
  typedef enum logic [1:0] {
    RP_IDLE,
    RP_HOLD,
    RP_REPEAT
  } rptState_e;

  rptState_e               state_q [N_CH];
  rptState_e               state_d [N_CH];
  logic [N_CH-1:0][CW-1:0] rc_q, rc_d;
  logic [N_CH-1:0]         rpt_q, rpt_d;

  // Acceptance strobes (rise_d/fall_d) steer the FSM so a release cancels a repeat due that same edge.
  always_comb begin
    rc_d  = rc_q;
    rpt_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        RP_IDLE: begin
          if (rise_d[i]) begin
            state_d[i] = RP_HOLD;
            rc_d[i]    = '0;
          end
        end
        RP_HOLD: begin
          if (fall_d[i]) begin
            state_d[i] = RP_IDLE;
            rc_d[i]    = '0;
          end else if (tick) begin
            if (rc_q[i] == CW'(HOLD - 1)) begin
              rpt_d[i]   = 1'b1;
              rc_d[i]    = '0;
              state_d[i] = RP_REPEAT;
            end else begin
              rc_d[i] = rc_q[i] + 1'b1;
            end
          end
        end
        RP_REPEAT: begin
          if (fall_d[i]) begin
            state_d[i] = RP_IDLE;
            rc_d[i]    = '0;
          end else if (tick) begin
            if (rc_q[i] == CW'(RPT - 1)) begin
              rpt_d[i] = 1'b1;
              rc_d[i]  = '0;
            end else begin
              rc_d[i] = rc_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = RP_IDLE;
          rc_d[i]    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= RP_IDLE;
      end
      rc_q  <= '0;
      rpt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
      end
      rc_q  <= rc_d;
      rpt_q <= rpt_d;
    end
  end

  assign bus.repeat_o = rpt_q;
`else
  assign bus.repeat_o = '0;
`endif

endmodule
